mem_access: RTL and testbench



---
 rtl/mem_access.sv | 211 +++++++++++++++++++++
 tb/tb_mem_access.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access stage: byte-lane load/store over a single-outstanding req/ack bus.
// Stalls the pipeline while a transaction is in flight, then registers the write-back result.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    output logic        stallreq_o,
    output logic        valid_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        addr_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic        kill_q, kill_d;
    logic        valid_q, valid_d;
    logic [4:0]  wd_q, wd_d;
    logic        wreg_q, wreg_d;
    logic [31:0] wdata_q, wdata_d;
    logic        addr_err_q, addr_err_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    // Details of the in-flight access, needed to shape the load result at ack time
    logic [7:0]  op_q, op_d;
    logic [1:0]  lane_q, lane_d;
    logic [4:0]  pend_wd_q, pend_wd_d;
    logic        pend_wreg_q, pend_wreg_d;

    logic        is_load, is_store, is_half, is_word, misaligned, start;
    logic [3:0]  sel;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        is_load  = (aluop_i == EXE_LB_OP) || (aluop_i == EXE_LBU_OP) || (aluop_i == EXE_LH_OP)
                || (aluop_i == EXE_LHU_OP) || (aluop_i == EXE_LW_OP);
        is_store = (aluop_i == EXE_SB_OP) || (aluop_i == EXE_SH_OP) || (aluop_i == EXE_SW_OP);
        is_half  = (aluop_i == EXE_LH_OP) || (aluop_i == EXE_LHU_OP) || (aluop_i == EXE_SH_OP);
        is_word  = (aluop_i == EXE_LW_OP) || (aluop_i == EXE_SW_OP);
        misaligned = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));
        start    = (state_q == IDLE) && valid_i && !flush_i && (is_load || is_store) && !misaligned;

        if (is_word) begin
            sel     = 4'b1111;
            st_data = reg2_i;
        end else if (is_half) begin
            sel     = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            st_data = {2{reg2_i[15:0]}};
        end else begin
            sel     = 4'b1000 >> mem_addr_i[1:0];
            st_data = {4{reg2_i[7:0]}};
        end
    end

    // Big-endian lane extraction from the read data of the pending load
    always_comb begin
        case (lane_q)
            2'b00:   ld_byte = bus_rdata_i[31:24];
            2'b01:   ld_byte = bus_rdata_i[23:16];
            2'b10:   ld_byte = bus_rdata_i[15:8];
            default: ld_byte = bus_rdata_i[7:0];
        endcase
        ld_half = lane_q[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
        case (op_q)
            EXE_LB_OP:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            EXE_LBU_OP: ld_data = {24'h0, ld_byte};
            EXE_LH_OP:  ld_data = {{16{ld_half[15]}}, ld_half};
            EXE_LHU_OP: ld_data = {16'h0, ld_half};
            EXE_LW_OP:  ld_data = bus_rdata_i;
            default:    ld_data = 32'h0;
        endcase
    end

    assign stallreq_o = start || ((state_q == BUSY) && !bus_ack_i);

    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        valid_d     = 1'b0;
        addr_err_d  = 1'b0;
        wd_d        = wd_q;
        wreg_d      = wreg_q;
        wdata_d     = wdata_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
        op_d        = op_q;
        lane_d      = lane_q;
        pend_wd_d   = pend_wd_q;
        pend_wreg_d = pend_wreg_q;

        if (state_q == IDLE) begin
            if (start) begin
                state_d     = BUSY;
                kill_d      = 1'b0;
                bus_req_d   = 1'b1;
                bus_we_d    = is_store;
                bus_addr_d  = {mem_addr_i[31:2], 2'b00};
                bus_sel_d   = sel;
                bus_wdata_d = st_data;
                op_d        = aluop_i;
                lane_d      = mem_addr_i[1:0];
                pend_wd_d   = wd_i;
                pend_wreg_d = wreg_i;
            end else if (valid_i && !flush_i) begin
                valid_d    = 1'b1;
                wd_d       = wd_i;
                addr_err_d = misaligned;
                wreg_d     = misaligned ? 1'b0 : wreg_i;
                wdata_d    = misaligned ? 32'h0 : wdata_i;
            end
        end else begin
            kill_d = kill_q || flush_i;
            if (bus_ack_i) begin
                state_d   = IDLE;
                kill_d    = 1'b0;
                bus_req_d = 1'b0;
                // A killed transaction still has to finish on the bus, but it retires nothing
                if (!(kill_q || flush_i)) begin
                    valid_d = 1'b1;
                    wd_d    = pend_wd_q;
                    wreg_d  = bus_we_q ? 1'b0 : pend_wreg_q;
                    wdata_d = bus_we_q ? 32'h0 : ld_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            kill_q      <= 1'b0;
            valid_q     <= 1'b0;
            wd_q        <= 5'h0;
            wreg_q      <= 1'b0;
            wdata_q     <= 32'h0;
            addr_err_q  <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_sel_q   <= 4'h0;
            bus_wdata_q <= 32'h0;
            op_q        <= 8'h0;
            lane_q      <= 2'b00;
            pend_wd_q   <= 5'h0;
            pend_wreg_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            valid_q     <= valid_d;
            wd_q        <= wd_d;
            wreg_q      <= wreg_d;
            wdata_q     <= wdata_d;
            addr_err_q  <= addr_err_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            pend_wd_q   <= pend_wd_d;
            pend_wreg_q <= pend_wreg_d;
        end
    end

    assign valid_o     = valid_q;
    assign wd_o        = wd_q;
    assign wreg_o      = wreg_q;
    assign wdata_o     = wdata_q;
    assign addr_err_o  = addr_err_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_sel_o   = bus_sel_q;
    assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access.
module tb_mem_access;

    localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;

    logic        clk = 1'b0, rst = 1'b0;
    logic        valid_i = 1'b0, flush_i = 1'b0, wreg_i = 1'b0, bus_ack_i = 1'b0;
    logic [7:0]  aluop_i = 8'h0;
    logic [31:0] mem_addr_i = 32'h0, reg2_i = 32'h0, wdata_i = 32'h0, bus_rdata_i = 32'h0;
    logic [4:0]  wd_i = 5'h0;
    logic        stallreq_o, valid_o, wreg_o, addr_err_o, bus_req_o, bus_we_o;
    logic [4:0]  wd_o;
    logic [31:0] wdata_o, bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_sel_o;

    int nchk = 0, nerr = 0;

    // Observations gathered by do_mem
    int          o_stall;
    logic        o_req_drop, o_we, o_valid, o_wreg, o_err, o_req_after;
    logic [31:0] o_addr, o_wdata_bus, o_wdata;
    logic [3:0]  o_sel;

    mem_access dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .aluop_i(aluop_i),
        .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wdata_i(wdata_i), .stallreq_o(stallreq_o), .valid_o(valid_o), .wd_o(wd_o),
        .wreg_o(wreg_o), .wdata_o(wdata_o), .addr_err_o(addr_err_o), .bus_req_o(bus_req_o),
        .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
        .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk = ~clk;

    // Runs one aligned memory op: ack arrives after `waits` BUSY cycles, optional flush in BUSY cycle flush_at
    task automatic do_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                          input logic [31:0] rdata, input int waits, input int flush_at);
        @(posedge clk); #1;
        valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; reg2_i = r2;
        wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hDEAD_0000;
        o_stall = 0; o_req_drop = 1'b0;
        @(negedge clk);
        if (stallreq_o) o_stall++;
        for (int w = 0; w <= waits; w++) begin
            @(posedge clk); #1;
            flush_i     = (w == flush_at);
            bus_ack_i   = (w == waits);
            bus_rdata_i = (w == waits) ? rdata : 32'h0;
            @(negedge clk);
            if (stallreq_o) o_stall++;
            if (!bus_req_o) o_req_drop = 1'b1;
            if (w == 0) begin
                o_we = bus_we_o; o_addr = bus_addr_o; o_sel = bus_sel_o; o_wdata_bus = bus_wdata_o;
            end
        end
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        @(negedge clk);
        o_valid = valid_o; o_wreg = wreg_o; o_wdata = wdata_o; o_err = addr_err_o;
        o_req_after = bus_req_o;
    endtask

    task automatic test_reset();
        #12;
        nchk++;
        if ({valid_o, wreg_o, addr_err_o, bus_req_o, bus_we_o, stallreq_o} !== 6'b0) begin
            nerr++; $display("FAIL reset_ctrl got %b exp 000000",
                {valid_o, wreg_o, addr_err_o, bus_req_o, bus_we_o, stallreq_o});
        end
        nchk++;
        if ({wd_o, wdata_o, bus_addr_o, bus_sel_o, bus_wdata_o} !== 105'b0) begin
            nerr++; $display("FAIL reset_data got wd=%h wdata=%h addr=%h sel=%h bwd=%h exp all 0",
                wd_o, wdata_o, bus_addr_o, bus_sel_o, bus_wdata_o);
        end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_nonmem();
        @(posedge clk); #1;
        valid_i = 1'b1; aluop_i = EXE_OR_OP; wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h1234;
        @(negedge clk);
        nchk++;
        if (stallreq_o !== 1'b0) begin nerr++; $display("FAIL nonmem_stall got %b exp 0", stallreq_o); end
        @(posedge clk); #1; valid_i = 1'b0;
        @(negedge clk);
        nchk++;
        if ({valid_o, wd_o, wreg_o, wdata_o} !== {1'b1, 5'd3, 1'b1, 32'h1234}) begin
            nerr++; $display("FAIL nonmem_wb got v=%b wd=%0d wreg=%b wdata=%h exp v=1 wd=3 wreg=1 wdata=00001234",
                valid_o, wd_o, wreg_o, wdata_o);
        end
        @(negedge clk);
        nchk++;
        if (valid_o !== 1'b0) begin nerr++; $display("FAIL nonmem_valid_drop got %b exp 0", valid_o); end
    endtask

    task automatic test_loads();
        logic [7:0]  ops [4]   = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP};
        logic [31:0] addrs [4] = '{32'h1001, 32'h1001, 32'h1002, 32'h1000};
        logic [31:0] rds [4]   = '{32'h11F0_3344, 32'h11F0_3344, 32'h0000_8001, 32'h9ABC_0000};
        logic [3:0]  sels [4]  = '{4'b0100, 4'b0100, 4'b0011, 4'b1100};
        logic [31:0] exps [4]  = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8001, 32'h0000_9ABC};
        for (int i = 0; i < 4; i++) begin
            do_mem(ops[i], addrs[i], 32'h0, rds[i], 3, -1);
            nchk++;
            if (o_stall !== 4) begin nerr++; $display("FAIL load%0d_stall_cycles got %0d exp 4", i, o_stall); end
            nchk++;
            if ({o_we, o_addr, o_sel, o_req_drop} !== {1'b0, addrs[i] & 32'hFFFF_FFFC, sels[i], 1'b0}) begin
                nerr++; $display("FAIL load%0d_bus got we=%b addr=%h sel=%b drop=%b exp we=0 addr=%h sel=%b drop=0",
                    i, o_we, o_addr, o_sel, o_req_drop, addrs[i] & 32'hFFFF_FFFC, sels[i]);
            end
            nchk++;
            if ({o_valid, o_wreg, o_wdata, o_req_after} !== {1'b1, 1'b1, exps[i], 1'b0}) begin
                nerr++; $display("FAIL load%0d_result got v=%b wreg=%b wdata=%h req=%b exp v=1 wreg=1 wdata=%h req=0",
                    i, o_valid, o_wreg, o_wdata, o_req_after, exps[i]);
            end
        end
    endtask

    task automatic test_store();
        do_mem(EXE_SH_OP, 32'h2002, 32'hAAAA_BEEF, 32'h0, 0, -1);
        nchk++;
        if ({o_we, o_addr, o_sel, o_wdata_bus} !== {1'b1, 32'h2000, 4'b0011, 32'hBEEF_BEEF}) begin
            nerr++; $display("FAIL sh_bus got we=%b addr=%h sel=%b wdata=%h exp we=1 addr=00002000 sel=0011 wdata=beefbeef",
                o_we, o_addr, o_sel, o_wdata_bus);
        end
        nchk++;
        if ({o_valid, o_wreg, o_wdata, o_stall} !== {1'b1, 1'b0, 32'h0, 32'd1}) begin
            nerr++; $display("FAIL sh_result got v=%b wreg=%b wdata=%h stall=%0d exp v=1 wreg=0 wdata=0 stall=1",
                o_valid, o_wreg, o_wdata, o_stall);
        end
    endtask

    task automatic test_misaligned();
        @(posedge clk); #1;
        valid_i = 1'b1; aluop_i = EXE_LW_OP; mem_addr_i = 32'h3002; wd_i = 5'd9; wreg_i = 1'b1;
        wdata_i = 32'h5555_5555;
        @(negedge clk);
        nchk++;
        if ({stallreq_o, bus_req_o} !== 2'b00) begin
            nerr++; $display("FAIL misalign_noreq got stall=%b req=%b exp 0 0", stallreq_o, bus_req_o);
        end
        @(posedge clk); #1; valid_i = 1'b0;
        @(negedge clk);
        nchk++;
        if ({valid_o, addr_err_o, wreg_o, wdata_o, bus_req_o} !== {1'b1, 1'b1, 1'b0, 32'h0, 1'b0}) begin
            nerr++; $display("FAIL misalign_result got v=%b err=%b wreg=%b wdata=%h req=%b exp v=1 err=1 wreg=0 wdata=0 req=0",
                valid_o, addr_err_o, wreg_o, wdata_o, bus_req_o);
        end
        @(negedge clk);
        nchk++;
        if (addr_err_o !== 1'b0) begin nerr++; $display("FAIL misalign_pulse got %b exp 0", addr_err_o); end
    endtask

    task automatic test_flush_busy();
        do_mem(EXE_LW_OP, 32'h4000, 32'h0, 32'h7777_7777, 4, 1);
        nchk++;
        if ({o_req_drop, o_addr} !== {1'b0, 32'h4000}) begin
            nerr++; $display("FAIL flush_req_held got drop=%b addr=%h exp drop=0 addr=00004000", o_req_drop, o_addr);
        end
        nchk++;
        if ({o_valid, o_req_after} !== 2'b00) begin
            nerr++; $display("FAIL flush_result got v=%b req=%b exp 0 0", o_valid, o_req_after);
        end
        // Stray ack while idle must not produce a write-back
        @(posedge clk); #1; bus_ack_i = 1'b1; bus_rdata_i = 32'h1;
        @(posedge clk); #1; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        @(negedge clk);
        nchk++;
        if ({valid_o, bus_req_o, stallreq_o} !== 3'b000) begin
            nerr++; $display("FAIL idle_ack got v=%b req=%b stall=%b exp 000", valid_o, bus_req_o, stallreq_o);
        end
    endtask

    task automatic test_reset_busy();
        @(posedge clk); #1;
        valid_i = 1'b1; aluop_i = EXE_LW_OP; mem_addr_i = 32'h6004; reg2_i = 32'h0; wd_i = 5'd4; wreg_i = 1'b1;
        @(posedge clk); #1;
        nchk++;
        if (bus_req_o !== 1'b1) begin nerr++; $display("FAIL rstbusy_req_up got %b exp 1", bus_req_o); end
        #2; rst = 1'b0; valid_i = 1'b0;
        #1;
        nchk++;
        if ({bus_req_o, stallreq_o, valid_o, wreg_o, bus_addr_o, bus_sel_o} !== 40'b0) begin
            nerr++; $display("FAIL rstbusy_async got req=%b stall=%b v=%b wreg=%b addr=%h sel=%b exp all 0",
                bus_req_o, stallreq_o, valid_o, wreg_o, bus_addr_o, bus_sel_o);
        end
        @(negedge clk); rst = 1'b1;
        do_mem(EXE_LW_OP, 32'h5000, 32'h0, 32'hCAFE_BABE, 0, -1);
        nchk++;
        if ({o_addr, o_sel, o_stall} !== {32'h5000, 4'b1111, 32'd1}) begin
            nerr++; $display("FAIL post_rst_bus got addr=%h sel=%b stall=%0d exp addr=00005000 sel=1111 stall=1",
                o_addr, o_sel, o_stall);
        end
        nchk++;
        if ({o_valid, o_wreg, o_wdata} !== {1'b1, 1'b1, 32'hCAFE_BABE}) begin
            nerr++; $display("FAIL post_rst_result got v=%b wreg=%b wdata=%h exp v=1 wreg=1 wdata=cafebabe",
                o_valid, o_wreg, o_wdata);
        end
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_loads();
        test_store();
        test_misaligned();
        test_flush_busy();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
